// File: rtl/multdiv_ctrl_defs.sv
// ============================================================================
// Package : multdiv_ctrl_defs
// Shared state encodings, opcode fields and rstatus codes for the multdiv
// sequencer and the execute-stage exception logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_ctrl_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_e;

   localparam logic [4:0] OPC_ALU   = 5'b00000;
   localparam logic [4:0] ALUOP_MUL = 5'b00110;
   localparam logic [4:0] ALUOP_DIV = 5'b00111;

   localparam int RSTATUS_MUL_CODE = 4;
   localparam int RSTATUS_DIV_CODE = 5;

endpackage

`default_nettype wire

// File: rtl/multdiv_seq_ctrl.sv
// ============================================================================
// Module  : multdiv_seq_ctrl
// Freezes the front of the pipeline while the multdiv unit works and releases
// its result into the X stage for one cycle. Optional macro: MULTDIV_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_seq_ctrl
   import multdiv_ctrl_defs::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_W       = 5,
   parameter int RSTATUS_MUL = RSTATUS_MUL_CODE,
   parameter int RSTATUS_DIV = RSTATUS_DIV_CODE,
   parameter int TIMEOUT     = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dx_is_mul,
   input  logic              dx_is_div,
   input  logic [DATA_W-1:0] dx_operandA,
   input  logic [DATA_W-1:0] dx_operandB,
   input  logic              flush,
   input  logic              md_ready,
   input  logic [DATA_W-1:0] md_result,
   input  logic              md_exception,
   output logic              md_ctrl_mult,
   output logic              md_ctrl_div,
   output logic [DATA_W-1:0] md_operandA,
   output logic [DATA_W-1:0] md_operandB,
   output logic              stall,
   output logic              bubble_xm,
   output logic              result_valid,
   output logic [DATA_W-1:0] result_out,
   output logic              exception_out,
   output logic [DATA_W-1:0] rstatus_out
);

   md_state_e         state_q, state_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              is_div_q, is_div_d;
   logic              exc_q, exc_d;
   logic              rs_div_q, rs_div_d;
   logic              issue;
   logic              timeout_hit;

   assign issue = (dx_is_mul | dx_is_div) & ~flush;

`ifdef MULTDIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The cycle that would bring the count up to TIMEOUT is the last BUSY cycle.
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_START) begin
         cnt_d = '0;
      end else if (state_q == ST_BUSY) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         is_div_q <= 1'b0;
         exc_q    <= 1'b0;
         rs_div_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
         is_div_q <= is_div_d;
         exc_q    <= exc_d;
         rs_div_q <= rs_div_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      is_div_d = is_div_q;
      exc_d    = exc_q;
      rs_div_d = rs_div_q;

      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               opa_d    = dx_operandA;
               opb_d    = dx_operandB;
               is_div_d = dx_is_div;
               // Divide-by-zero is resolved here; the unit is never started.
               if (dx_is_div && (dx_operandB == '0)) begin
                  res_d    = '0;
                  exc_d    = 1'b1;
                  rs_div_d = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_START;
               end
            end
         end
         ST_START: begin
            state_d = flush ? ST_IDLE : ST_BUSY;
         end
         ST_BUSY: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (md_ready) begin
               res_d    = md_exception ? '0 : md_result;
               exc_d    = md_exception;
               rs_div_d = is_div_q;
               state_d  = ST_DONE;
            end else if (timeout_hit) begin
               res_d    = '0;
               exc_d    = 1'b1;
               rs_div_d = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      md_ctrl_mult  = 1'b0;
      md_ctrl_div   = 1'b0;
      md_operandA   = '0;
      md_operandB   = '0;
      stall         = 1'b0;
      result_valid  = 1'b0;
      result_out    = '0;
      exception_out = 1'b0;
      rstatus_out   = '0;

      if (reset) begin
         md_operandA  = opa_q;
         md_operandB  = opb_q;
         stall        = ((state_q == ST_IDLE) & issue) |
                        (state_q == ST_START) | (state_q == ST_BUSY);
         md_ctrl_mult = (state_q == ST_START) & ~flush & ~is_div_q;
         md_ctrl_div  = (state_q == ST_START) & ~flush &  is_div_q;
         result_valid = (state_q == ST_DONE) & ~flush;
         if (result_valid) begin
            result_out    = res_q;
            exception_out = exc_q;
            if (exc_q) begin
               rstatus_out = rs_div_q ? DATA_W'(RSTATUS_DIV) : DATA_W'(RSTATUS_MUL);
            end
         end
      end
      bubble_xm = stall;
   end

endmodule

`default_nettype wire
